// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Ports: none; master drives req/addr, slave drives ack/data.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;

    modport master (
        output req,
        output addr,
        input  ack,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with PC, single-outstanding imem request and IF/ID register.
// Ports: clk_i, rst_i (async active-low), start_i, PCWrite_i/IFIDWrite_i (stall),
//        Flush_i/BranchTarget_i (redirect), imem (master bus), PC_o, IFID*_o, StallCnt_o.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        IFIDWrite_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    if_stage_if.master  imem,
    output logic [31:0] PC_o,
    output logic [31:0] IFIDPC_o,
    output logic [31:0] IFIDInstr_o,
    output logic        IFIDValid_o,
    output logic [15:0] StallCnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        stall;
    logic [31:0] pc_plus4;

    assign stall    = PCWrite_i | IFIDWrite_i;
    assign pc_plus4 = pc_q + 32'd4;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush outranks stall and ack
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (Flush_i)                 state_d = S_FETCH;
                else if (stall && imem.ack)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (Flush_i || !stall) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and PC
    always_comb begin
        imem.req  = (state_q == S_FETCH);
        imem.addr = pc_q;
    end

    // Datapath next values
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        hold_buf_d   = hold_buf_q;
        stall_cnt_d  = stall_cnt_q;

        if (state_q != S_IDLE && stall && !Flush_i
            && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        unique case (state_q)
            S_FETCH: begin
                if (Flush_i) begin
                    ifid_pc_d    = 32'd0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    pc_d         = BranchTarget_i;
                    hold_buf_d   = NOP;
                end else if (stall) begin
                    // Word arriving under a stall is parked until release
                    if (imem.ack) hold_buf_d = imem.data;
                end else if (imem.ack) begin
                    ifid_pc_d    = pc_plus4;
                    ifid_instr_d = imem.data;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                end else begin
                    // Bubble keeps the last IFIDPC value
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (Flush_i) begin
                    ifid_pc_d    = 32'd0;
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                    pc_d         = BranchTarget_i;
                    hold_buf_d   = NOP;
                end else if (!stall) begin
                    ifid_pc_d    = pc_plus4;
                    ifid_instr_d = hold_buf_q;
                    ifid_valid_d = 1'b1;
                    pc_d         = pc_plus4;
                    hold_buf_d   = NOP;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            hold_buf_q   <= NOP;
            stall_cnt_q  <= 16'd0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            hold_buf_q   <= hold_buf_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign PC_o        = pc_q;
    assign IFIDPC_o    = ifid_pc_q;
    assign IFIDInstr_o = ifid_instr_q;
    assign IFIDValid_o = ifid_valid_q;
    assign StallCnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized run against a model.
// Ports: none.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        pcw = 1'b0;
    logic        ifw = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hA500_0001;
    endfunction

    if_stage_if m0 ();
    if_stage_if m1 ();

    assign m0.ack  = ack;
    assign m0.data = ins(m0.addr);
    assign m1.ack  = ack;
    assign m1.data = ins(m1.addr);

    logic [31:0] pc0, ifpc0, ifin0, pc1, ifpc1, ifin1;
    logic        ifv0, ifv1;
    logic [15:0] cnt0, cnt1;

    if_stage u0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .PCWrite_i(pcw), .IFIDWrite_i(ifw), .Flush_i(flush),
        .BranchTarget_i(tgt), .imem(m0),
        .PC_o(pc0), .IFIDPC_o(ifpc0), .IFIDInstr_o(ifin0),
        .IFIDValid_o(ifv0), .StallCnt_o(cnt0)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .PCWrite_i(pcw), .IFIDWrite_i(ifw), .Flush_i(flush),
        .BranchTarget_i(tgt), .imem(m1),
        .PC_o(pc1), .IFIDPC_o(ifpc1), .IFIDInstr_o(ifin1),
        .IFIDValid_o(ifv1), .StallCnt_o(cnt1)
    );

    // {req, addr, ifid_pc, ifid_instr, ifid_valid, stall_cnt}
    function automatic logic [113:0] obs0();
        return {m0.req, m0.addr, ifpc0, ifin0, ifv0, cnt0};
    endfunction

    function automatic logic [113:0] mk(input logic r, input logic [31:0] a,
                                        input logic [31:0] p, input logic [31:0] i,
                                        input logic v, input logic [15:0] c);
        return {r, a, p, i, v, c};
    endfunction

    task automatic cyc(input logic s, input logic [1:0] st, input logic f,
                       input logic [31:0] t, input logic a);
        start = s; pcw = st[0]; ifw = st[1]; flush = f; tgt = t; ack = a;
        @(posedge clk);
        #1;
        start = 1'b0; pcw = 1'b0; ifw = 1'b0; flush = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [113:0] e;
        #1 rst_n = 1'b0;
        #2;
        e = mk(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs0(), e);
        end
        checks++;
        if ({m1.req, pc1} !== {1'b0, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL reset_pc1 got %h exp %h", {m1.req, pc1}, {1'b0, 32'hFFFF_FFFC});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
        checks++;
        if (m0.req !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req got %b exp 0", m0.req);
        end
    endtask

    task automatic test_zero_latency();
        logic [113:0] e;
        do_reset();
        cyc(1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
        e = mk(1'b1, 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL zl_start got %h exp %h", obs0(), e);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
            e = mk(1'b1, 32'(4 * (k + 1)), 32'(4 * (k + 1)),
                   ins(32'(4 * k)), 1'b1, 16'd0);
            checks++;
            if (obs0() !== e) begin
                errors++;
                $display("FAIL zl_fetch%0d got %h exp %h", k, obs0(), e);
            end
        end
    endtask

    task automatic test_latency2();
        logic [113:0] e;
        // continues from PC=12 with IF/ID={12,I8,1}
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 2; w++) begin
                cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
                e = mk(1'b1, 32'(12 + 4 * n), 32'(12 + 4 * n), 32'd0, 1'b0, 16'd0);
                checks++;
                if (obs0() !== e) begin
                    errors++;
                    $display("FAIL lat2_wait%0d_%0d got %h exp %h", n, w, obs0(), e);
                end
            end
            cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
            e = mk(1'b1, 32'(16 + 4 * n), 32'(16 + 4 * n),
                   ins(32'(12 + 4 * n)), 1'b1, 16'd0);
            checks++;
            if (obs0() !== e) begin
                errors++;
                $display("FAIL lat2_ack%0d got %h exp %h", n, obs0(), e);
            end
        end
    endtask

    task automatic test_stall_hold();
        logic [113:0] e;
        do_reset();
        cyc(1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
        e = mk(1'b0, 32'd8, 32'd8, ins(32'd4), 1'b1, 16'd1);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL hold_1 got %h exp %h", obs0(), e);
        end
        cyc(1'b0, 2'b10, 1'b0, 32'd0, 1'b0);
        e = mk(1'b0, 32'd8, 32'd8, ins(32'd4), 1'b1, 16'd2);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL hold_2 got %h exp %h", obs0(), e);
        end
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b0);
        e = mk(1'b1, 32'd12, 32'd12, ins(32'd8), 1'b1, 16'd2);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL hold_release got %h exp %h", obs0(), e);
        end
    endtask

    task automatic test_flush();
        logic [113:0] e;
        // continues from PC=12, StallCnt=2
        cyc(1'b0, 2'b11, 1'b1, 32'h40, 1'b1);
        e = mk(1'b1, 32'h40, 32'd0, 32'd0, 1'b0, 16'd2);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL flush got %h exp %h", obs0(), e);
        end
        // flush out of HOLD
        cyc(1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 2'b01, 1'b1, 32'h123, 1'b0);
        e = mk(1'b1, 32'h123, 32'd0, 32'd0, 1'b0, 16'd3);
        checks++;
        if (obs0() !== e) begin
            errors++;
            $display("FAIL flush_hold got %h exp %h", obs0(), e);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
        checks++;
        if ({m1.req, m1.addr, ifpc1, ifin1, ifv1}
            !== {1'b1, 32'd0, 32'd0, ins(32'hFFFF_FFFC), 1'b1}) begin
            errors++;
            $display("FAIL wrap got %h exp %h", {m1.req, m1.addr, ifpc1, ifin1, ifv1},
                     {1'b1, 32'd0, 32'd0, ins(32'hFFFF_FFFC), 1'b1});
        end
    endtask

    task automatic test_saturate_async_reset();
        logic [113:0] e;
        do_reset();
        cyc(1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc(1'b0, 2'b00, 1'b0, 32'd0, 1'b1);
        pcw = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if ({cnt0, m0.req, pc0} !== {16'hFFFF, 1'b1, 32'd4}) begin
            errors++;
            $display("FAIL saturate got %h exp %h", {cnt0, m0.req, pc0}, {16'hFFFF, 1'b1, 32'd4});
        end
        pcw = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        e = mk(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        checks++;
        if ({obs0(), pc0} !== {e, 32'd0}) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", {obs0(), pc0}, {e, 32'd0});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) cyc(1'b0, 2'b01, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({m0.req, cnt0} !== {1'b0, 16'd0}) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp %h", {m0.req, cnt0}, {1'b0, 16'd0});
        end
        cyc(1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
        checks++;
        if ({m0.req, m0.addr} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL restart got %h exp %h", {m0.req, m0.addr}, {1'b1, 32'd0});
        end
    endtask

    task automatic test_random();
        bit          on, have;
        logic [31:0] pc, word, epc, ein;
        bit          ev;
        logic [15:0] ec;
        logic [113:0] e;
        do_reset();
        on = 0; have = 0; pc = 32'd0; word = 32'd0;
        epc = 32'd0; ein = 32'd0; ev = 0; ec = 16'd0;
        repeat (600) begin
            bit          s, f, a;
            logic [1:0]  st;
            logic [31:0] t, d;
            s  = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            f  = ($urandom_range(0, 9) == 0);
            t  = $urandom();
            a  = on && !have && ($urandom_range(0, 2) != 0);
            d  = ins(pc);
            cyc(s, st, f, t, a);
            if (!on) begin
                if (s) on = 1;
            end else if (f) begin
                epc = 32'd0; ein = 32'd0; ev = 0; pc = t; have = 0;
            end else if (st != 2'b00) begin
                if (ec != 16'hFFFF) ec = ec + 16'd1;
                if (!have && a) begin
                    have = 1; word = d;
                end
            end else if (have) begin
                epc = pc + 32'd4; ein = word; ev = 1; pc = pc + 32'd4; have = 0;
            end else if (a) begin
                epc = pc + 32'd4; ein = d; ev = 1; pc = pc + 32'd4;
            end else begin
                ein = 32'd0; ev = 0;
            end
            e = mk(on && !have, pc, epc, ein, ev, ec);
            checks++;
            if (obs0() !== e || pc0 !== pc) begin
                errors++;
                $display("FAIL random got %h/%h exp %h/%h", obs0(), pc0, e, pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_latency2();
        test_stall_hold();
        test_flush();
        test_wrap();
        test_random();
        test_saturate_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
